// File: rtl/escalonador_pkg.sv
// Shared definitions for the ultrasonic sensor scheduler: FSM state codes,
// sensor count and the all-sensors-failed flag pattern.
package escalonador_pkg;

  localparam int unsigned N_SENSORES = 3;
  localparam logic [N_SENSORES-1:0] FALHA_TOTAL = 3'b111;

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    PREPARA   = 4'd1,
    DISPARA   = 4'd2,
    ESPERA    = 4'd3,
    GRAVA     = 4'd4,
    TIMEOUT   = 4'd5,
    INTERVALO = 4'd6,
    PROXIMO   = 4'd7,
    CALCULA   = 4'd8,
    FIM       = 4'd9
  } estado_t;

endpackage

// File: rtl/fusao_medidas.sv
// Combinational fusion of up to three sensor readings into one distance.
// SENSOR_MINIMO_EN: with 2 or 3 valid readings, take the minimum instead of median/average.
module fusao_medidas
  import escalonador_pkg::*;
#(
  parameter int unsigned DIST_W = 12
) (
  input  logic [DIST_W-1:0]     leitura0,
  input  logic [DIST_W-1:0]     leitura1,
  input  logic [DIST_W-1:0]     leitura2,
  input  logic [N_SENSORES-1:0] valido,
  output logic [DIST_W-1:0]     distancia_c
);

  function automatic logic [DIST_W-1:0] minimo(input logic [DIST_W-1:0] a,
                                                input logic [DIST_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DIST_W-1:0] maximo(input logic [DIST_W-1:0] a,
                                                input logic [DIST_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

`ifdef SENSOR_MINIMO_EN
  // Conservative choice: the shortest distance means the highest water level.
  function automatic logic [DIST_W-1:0] par(input logic [DIST_W-1:0] a,
                                             input logic [DIST_W-1:0] b);
    return minimo(a, b);
  endfunction

  function automatic logic [DIST_W-1:0] trio(input logic [DIST_W-1:0] a,
                                              input logic [DIST_W-1:0] b,
                                              input logic [DIST_W-1:0] c);
    return minimo(minimo(a, b), c);
  endfunction
`else
  // Sum carried in one extra bit so the average never overflows.
  function automatic logic [DIST_W-1:0] par(input logic [DIST_W-1:0] a,
                                             input logic [DIST_W-1:0] b);
    logic [DIST_W:0] soma;
    soma = {1'b0, a} + {1'b0, b};
    return soma[DIST_W:1];
  endfunction

  function automatic logic [DIST_W-1:0] trio(input logic [DIST_W-1:0] a,
                                              input logic [DIST_W-1:0] b,
                                              input logic [DIST_W-1:0] c);
    return maximo(minimo(a, b), minimo(maximo(a, b), c));
  endfunction
`endif

  always_comb begin
    distancia_c = '0;
    case (valido)
      3'b111:  distancia_c = trio(leitura0, leitura1, leitura2);
      3'b011:  distancia_c = par(leitura0, leitura1);
      3'b101:  distancia_c = par(leitura0, leitura2);
      3'b110:  distancia_c = par(leitura1, leitura2);
      3'b001:  distancia_c = leitura0;
      3'b010:  distancia_c = leitura1;
      3'b100:  distancia_c = leitura2;
      default: distancia_c = '0;
    endcase
  end

endmodule

// File: rtl/escalonador_sensores.sv
// Sequences three ultrasonic sensors through one shared echo interface with a
// settling gap and per-sensor timeout, then fuses the readings (see fusao_medidas).
module escalonador_sensores
  import escalonador_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned GAP_CYCLES     = 3000000,
  parameter int unsigned DIST_W         = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              pronto_medida,
  input  logic [DIST_W-1:0] medida,
  output logic              medir,
  output logic [1:0]        sel_sensor,
  output logic [DIST_W-1:0] distancia,
  output logic [2:0]        falha,
  output logic              pronto,
  output logic              ocupado,
  output logic [3:0]        db_estado,
  output logic [3:0]        db_sensor
);

  localparam int unsigned MAX_CYCLES = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_TIMEOUT = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_GAP     = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [1:0]         ULTIMO        = 2'(N_SENSORES - 1);

  estado_t estado, estado_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [N_SENSORES-1:0] valido, valido_nxt;
  logic [N_SENSORES-1:0] falha_ronda, falha_ronda_nxt;
  logic [N_SENSORES-1:0][DIST_W-1:0] leituras, leituras_nxt;
  logic [1:0]        sel_nxt;
  logic [DIST_W-1:0] distancia_nxt;
  logic [2:0]        falha_nxt;
  logic              medir_nxt;
  logic              pronto_nxt;
  logic              ocupado_nxt;
  logic              em_slot;
  logic [3:0]        db_sensor_nxt;
  logic [DIST_W-1:0] fusao_c;

  fusao_medidas #(.DIST_W(DIST_W)) u_fusao (
    .leitura0    (leituras[0]),
    .leitura1    (leituras[1]),
    .leitura2    (leituras[2]),
    .valido      (valido),
    .distancia_c (fusao_c)
  );

  // Next-state, datapath and next-output logic
  always_comb begin
    estado_nxt      = estado;
    sel_nxt         = sel_sensor;
    valido_nxt      = valido;
    falha_ronda_nxt = falha_ronda;
    leituras_nxt    = leituras;
    distancia_nxt   = distancia;
    falha_nxt       = falha;

    unique case (estado)
      INICIAL: begin
        sel_nxt = 2'd0;
        if (iniciar) estado_nxt = PREPARA;
      end
      PREPARA: begin
        valido_nxt      = '0;
        falha_ronda_nxt = '0;
        estado_nxt      = DISPARA;
      end
      DISPARA: estado_nxt = ESPERA;
      // A reply on the last timeout cycle still counts as a valid reading.
      ESPERA: begin
        if (pronto_medida) begin
          estado_nxt = GRAVA;
          for (int k = 0; k < N_SENSORES; k++) begin
            if (sel_sensor == 2'(k)) leituras_nxt[k] = medida;
          end
        end else if (timer == TIMER_TIMEOUT) begin
          estado_nxt = TIMEOUT;
        end
      end
      GRAVA: begin
        for (int k = 0; k < N_SENSORES; k++) begin
          if (sel_sensor == 2'(k)) valido_nxt[k] = 1'b1;
        end
        estado_nxt = INTERVALO;
      end
      TIMEOUT: begin
        for (int k = 0; k < N_SENSORES; k++) begin
          if (sel_sensor == 2'(k)) begin
            falha_ronda_nxt[k] = 1'b1;
            valido_nxt[k]      = 1'b0;
          end
        end
        estado_nxt = INTERVALO;
      end
      INTERVALO: begin
        if (timer == TIMER_GAP) begin
          if (sel_sensor == ULTIMO) begin
            estado_nxt = CALCULA;
          end else begin
            estado_nxt = PROXIMO;
            sel_nxt    = sel_sensor + 2'd1;
          end
        end
      end
      PROXIMO: estado_nxt = DISPARA;
      // With no valid reading the previous distance is kept.
      CALCULA: begin
        if (valido == '0) begin
          falha_nxt = FALHA_TOTAL;
        end else begin
          falha_nxt     = falha_ronda;
          distancia_nxt = fusao_c;
        end
        estado_nxt = FIM;
      end
      FIM:     estado_nxt = INICIAL;
      default: estado_nxt = INICIAL;
    endcase

    if (estado_nxt != estado) begin
      timer_nxt = '0;
    end else if (estado == ESPERA || estado == INTERVALO) begin
      timer_nxt = timer + TIMER_W'(1);
    end else begin
      timer_nxt = '0;
    end

    medir_nxt     = (estado_nxt == DISPARA);
    pronto_nxt    = (estado_nxt == FIM);
    ocupado_nxt   = (estado_nxt != INICIAL);
    em_slot       = (estado_nxt inside {PREPARA, DISPARA, ESPERA, GRAVA, TIMEOUT, INTERVALO, PROXIMO});
    db_sensor_nxt = em_slot ? {1'b0, 3'b001 << sel_nxt} : 4'd0;
  end

  // State register plus registered outputs aligned with the state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado      <= INICIAL;
      timer       <= '0;
      valido      <= '0;
      falha_ronda <= '0;
      leituras    <= '0;
      sel_sensor  <= 2'd0;
      distancia   <= '0;
      falha       <= '0;
      medir       <= 1'b0;
      pronto      <= 1'b0;
      ocupado     <= 1'b0;
      db_estado   <= 4'd0;
      db_sensor   <= 4'd0;
    end else begin
      estado      <= estado_nxt;
      timer       <= timer_nxt;
      valido      <= valido_nxt;
      falha_ronda <= falha_ronda_nxt;
      leituras    <= leituras_nxt;
      sel_sensor  <= sel_nxt;
      distancia   <= distancia_nxt;
      falha       <= falha_nxt;
      medir       <= medir_nxt;
      pronto      <= pronto_nxt;
      ocupado     <= ocupado_nxt;
      db_estado   <= 4'(estado_nxt);
      db_sensor   <= db_sensor_nxt;
    end
  end

endmodule

// File: tb/tb_escalonador_sensores.sv
// Randomized bench for escalonador_sensores with a round-level reference model
// (short timeout/gap parameters so a full round stays a few hundred cycles).
module tb_escalonador_sensores;

  localparam int unsigned T  = 200;
  localparam int unsigned G  = 40;
  localparam int unsigned DW = 12;

  logic          clock;
  logic          reset;
  logic          iniciar;
  logic          pronto_medida;
  logic [DW-1:0] medida;
  logic          medir;
  logic [1:0]    sel_sensor;
  logic [DW-1:0] distancia;
  logic [2:0]    falha;
  logic          pronto;
  logic          ocupado;
  logic [3:0]    db_estado;
  logic [3:0]    db_sensor;

  escalonador_sensores #(
    .TIMEOUT_CYCLES (T),
    .GAP_CYCLES     (G),
    .DIST_W         (DW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .pronto_medida (pronto_medida),
    .medida        (medida),
    .medir         (medir),
    .sel_sensor    (sel_sensor),
    .distancia     (distancia),
    .falha         (falha),
    .pronto        (pronto),
    .ocupado       (ocupado),
    .db_estado     (db_estado),
    .db_sensor     (db_sensor)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int medir_cnt = 0;

  // Per-round scenario: reply enable, reply delay (cycles after medir), value
  bit            resp[3];
  int            dly[3];
  logic [DW-1:0] val[3];
  logic [DW-1:0] model_dist = '0;

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) if (medir) medir_cnt <= medir_cnt + 1;

  task automatic confere(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
    n_vec++;
    if (obtido !== esperado) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obtido, esperado, $time);
    end
  endtask

  // A reply counts only if it arrives within the timeout window
  function automatic bit valida(input int s);
    return resp[s] && (dly[s] <= int'(T));
  endfunction

  task automatic modelo(output logic [DW-1:0] d, output logic [2:0] f);
    logic [DW-1:0] q[$];
    f = 3'b000;
    for (int s = 0; s < 3; s++) begin
      if (valida(s)) q.push_back(val[s]);
      else f[s] = 1'b1;
    end
    q.sort();
    case (q.size())
      0: begin d = model_dist; f = 3'b111; end
      1: d = q[0];
`ifdef SENSOR_MINIMO_EN
      2: d = q[0];
      default: d = q[0];
`else
      2: d = DW'((13'(q[0]) + 13'(q[1])) >> 1);
      default: d = q[1];
`endif
    endcase
  endtask

  task automatic run_round(input bit injeta);
    int start, e_tot, c, esp, m0;
    logic [3:0] st;
    bit left, found;
    logic [DW-1:0] exp_d;
    logic [2:0] exp_f;
    modelo(exp_d, exp_f);
    m0 = medir_cnt;
    @(negedge clock);
    iniciar = 1'b1;
    start = cyc;
    @(negedge clock);
    iniciar = 1'b0;
    confere("ocupado_inicio", ocupado, 1);
    e_tot = 0;
    for (int s = 0; s < 3; s++) begin
      found = 0;
      for (int k = 0; k < int'(G) + 10; k++) begin
        if (medir) begin found = 1; break; end
        @(negedge clock);
        pronto_medida = 1'b0;
        iniciar = 1'b0;
      end
      confere("medir_visto", found, 1);
      if (!found) return;
      confere("sel_sensor", sel_sensor, s);
      confere("db_sensor", db_sensor, 32'(1 << s));
      c = 0; left = 0; st = '0; esp = 0;
      while (c < int'(T) + 3) begin
        @(negedge clock);
        c++;
        pronto_medida = 1'b0;
        iniciar = 1'b0;
        if (!left && db_estado != 4'd3) begin left = 1; st = db_estado; esp = c - 1; end
        if (resp[s] && c == dly[s]) begin pronto_medida = 1'b1; medida = val[s]; end
        if (injeta && s == 1 && c == 3) iniciar = 1'b1;
        if (left && (!resp[s] || c >= dly[s])) break;
      end
      confere("estado_apos_espera", st, valida(s) ? 4 : 5);
      confere("ciclos_espera", esp, valida(s) ? dly[s] : int'(T));
      e_tot += valida(s) ? dly[s] : int'(T);
    end
    found = 0;
    for (int k = 0; k < int'(G) + 20; k++) begin
      if (pronto) begin found = 1; break; end
      @(negedge clock);
      pronto_medida = 1'b0;
      iniciar = 1'b0;
    end
    confere("pronto_visto", found, 1);
    // PREPARA, then per slot DISPARA+ESPERA+GRAVA/TIMEOUT+gap, two PROXIMO, CALCULA, FIM
    confere("latencia", cyc - start, 5 + e_tot + 3 * (2 + int'(G)));
    confere("distancia", distancia, exp_d);
    confere("falha", falha, exp_f);
    confere("db_estado_fim", db_estado, 9);
    @(negedge clock);
    confere("pronto_pulso", pronto, 0);
    confere("ocupado_fim", ocupado, 0);
    confere("medir_total", medir_cnt - m0, 3);
    model_dist = exp_d;
  endtask

  task automatic reset_meio;
    bit found;
    int m0;
    m0 = medir_cnt;
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    found = 0;
    for (int k = 0; k < 2 * (int'(T) + int'(G)) + 20; k++) begin
      if (medir && sel_sensor == 2'd1) begin found = 1; break; end
      @(negedge clock);
    end
    confere("reset_medir1", found, 1);
    repeat (5) @(negedge clock);
    confere("reset_pre_espera", db_estado, 3);
    reset = 1'b1;
    #1;
    confere("reset_db_estado", db_estado, 0);
    confere("reset_medir", medir, 0);
    confere("reset_ocupado", ocupado, 0);
    confere("reset_sel", sel_sensor, 0);
    confere("reset_distancia", distancia, 0);
    confere("reset_falha", falha, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    confere("reset_sem_medir", medir_cnt - m0, 2);
    confere("reset_ocioso", db_estado, 0);
    model_dist = '0;
  endtask

  task automatic cenario(input bit r0, input bit r1, input bit r2,
                         input int d0, input int d1, input int d2,
                         input int v0, input int v1, input int v2);
    resp[0] = r0; resp[1] = r1; resp[2] = r2;
    dly[0] = d0; dly[1] = d1; dly[2] = d2;
    val[0] = DW'(v0); val[1] = DW'(v1); val[2] = DW'(v2);
  endtask

  initial begin
    reset = 1'b1;
    iniciar = 1'b0;
    pronto_medida = 1'b0;
    medida = '0;
    repeat (3) @(negedge clock);
    confere("rst_db_estado", db_estado, 0);
    confere("rst_medir", medir, 0);
    confere("rst_ocupado", ocupado, 0);
    confere("rst_distancia", distancia, 0);
    confere("rst_falha", falha, 0);
    confere("rst_db_sensor", db_sensor, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    cenario(1, 1, 1, 50, 50, 50, 300, 250, 400); run_round(0);
    cenario(1, 0, 1, 50, 0, 50, 300, 0, 400);    run_round(0);
    cenario(1, 1, 1, 50, 50, 50, 300, 250, 400); run_round(0);
    cenario(0, 0, 0, 0, 0, 0, 0, 0, 0);          run_round(0);
    cenario(1, 1, 1, T, 100, 7, 1234, 99, 4000); run_round(1);
    cenario(1, 1, 1, 20, 30, T + 1, 4095, 4093, 17); run_round(0);

    // A stray pronto_medida while idle must be ignored
    @(negedge clock);
    pronto_medida = 1'b1;
    medida = 12'd55;
    @(negedge clock);
    pronto_medida = 1'b0;
    @(negedge clock);
    confere("ocioso_ignora", db_estado, 0);
    confere("ocioso_distancia", distancia, model_dist);

    reset_meio();

    for (int r = 0; r < 12; r++) begin
      for (int s = 0; s < 3; s++) begin
        resp[s] = ($urandom_range(0, 3) != 0);
        val[s]  = DW'($urandom);
        case ($urandom_range(0, 4))
          0:       dly[s] = int'(T);
          1:       dly[s] = int'(T) + 1;
          default: dly[s] = int'($urandom_range(1, T - 1));
        endcase
      end
      run_round(1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
